// File: rtl/uart_boot_loader.sv
// Parses a framed program image from the UART byte stream, writes it into
// instruction memory word by word, and holds the core in reset until a good image lands.
module uart_boot_loader #(
  parameter logic [31:0] BOOT_BASE   = 32'h0040_0000,
  parameter logic [31:0] BOOT_END    = 32'h0040_3FFC,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRxValid,
  input  logic [7:0]  iRxData,
  output logic        oIwWriteEnable,
  output logic [31:0] oIwAddress,
  output logic [31:0] oIwWriteData,
  output logic [3:0]  oIwByteEnable,
  output logic        oCPUReset,
  output logic [31:0] oInitialPC,
  output logic        oBootDone,
  output logic        oError,
  output logic [1:0]  oErrCode
);

  // state   | meaning
  // IDLE    | waiting for magic byte after reset
  // ADDR    | collecting 4-byte start address
  // COUNT   | collecting 2-byte word count
  // CHECK   | one-cycle range/alignment check, no byte consumed
  // DATA    | collecting words and issuing writes
  // CSUM    | comparing checksum byte
  // DONE    | image accepted, core released
  // ERROR   | image rejected, core held
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_CHECK, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t      state, state_nxt;
  logic [31:0] start_addr;
  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [31:0] word_sr;
  logic [15:0] word_cnt;
  logic [31:0] wr_addr;
  logic [7:0]  csum_acc;
  logic [23:0] idle_cnt;

  logic        magic;
  logic        in_frame;
  logic        timeout_hit;
  logic        range_bad;
  logic [33:0] last_addr;

  assign oIwByteEnable = 4'hF;

  assign magic       = iRxValid && (iRxData == 8'hA5);
  assign in_frame    = (state == S_ADDR) || (state == S_COUNT) ||
                       (state == S_DATA) || (state == S_CSUM);
  assign timeout_hit = in_frame && !iRxValid && (idle_cnt == TIMEOUT_CYC - 24'd1);

  // 34-bit end address so that an image running past 4 GiB cannot wrap into range
  assign last_addr = {2'b00, start_addr} + {16'h0000, count - 16'd1, 2'b00};
  assign range_bad = (start_addr[1:0] != 2'b00) || (start_addr < BOOT_BASE) ||
                     ((count != 16'd0) && (last_addr > {2'b00, BOOT_END}));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = S_ERROR;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (magic) state_nxt = S_ADDR;
        S_ADDR:  if (iRxValid && byte_idx == 2'd3) state_nxt = S_COUNT;
        S_COUNT: if (iRxValid && byte_idx == 2'd1) state_nxt = S_CHECK;
        S_CHECK: begin
          if (range_bad)            state_nxt = S_ERROR;
          else if (count == 16'd0)  state_nxt = S_CSUM;
          else                      state_nxt = S_DATA;
        end
        S_DATA: if (iRxValid && byte_idx == 2'd3 && word_cnt == count - 16'd1)
                  state_nxt = S_CSUM;
        S_CSUM: if (iRxValid) state_nxt = (iRxData == csum_acc) ? S_DONE : S_ERROR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      start_addr     <= 32'h0;
      count          <= 16'h0;
      byte_idx       <= 2'd0;
      word_sr        <= 32'h0;
      word_cnt       <= 16'h0;
      wr_addr        <= 32'h0;
      csum_acc       <= 8'h0;
      idle_cnt       <= 24'h0;
      oIwWriteEnable <= 1'b0;
      oIwAddress     <= 32'h0;
      oIwWriteData   <= 32'h0;
      oCPUReset      <= 1'b1;
      oInitialPC     <= BOOT_BASE;
      oBootDone      <= 1'b0;
      oError         <= 1'b0;
      oErrCode       <= 2'b00;
    end else begin
      oIwWriteEnable <= 1'b0;
      idle_cnt       <= (in_frame && !iRxValid) ? idle_cnt + 24'd1 : 24'h0;

      if (timeout_hit) begin
        oError   <= 1'b1;
        oErrCode <= ERR_TIMEOUT;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (magic) begin
              csum_acc  <= 8'h0;
              byte_idx  <= 2'd0;
              oBootDone <= 1'b0;
              oError    <= 1'b0;
              oErrCode  <= 2'b00;
              oCPUReset <= 1'b1;
            end
          end
          S_ADDR: begin
            if (iRxValid) begin
              start_addr <= {iRxData, start_addr[31:8]};
              byte_idx   <= byte_idx + 2'd1;
              csum_acc   <= csum_acc ^ iRxData;
            end
          end
          S_COUNT: begin
            if (iRxValid) begin
              count    <= {iRxData, count[15:8]};
              byte_idx <= (byte_idx == 2'd1) ? 2'd0 : byte_idx + 2'd1;
              csum_acc <= csum_acc ^ iRxData;
            end
          end
          S_CHECK: begin
            wr_addr  <= start_addr;
            word_cnt <= 16'h0;
            if (range_bad) begin
              oError   <= 1'b1;
              oErrCode <= ERR_RANGE;
            end
          end
          S_DATA: begin
            if (iRxValid) begin
              word_sr  <= {iRxData, word_sr[31:8]};
              byte_idx <= byte_idx + 2'd1;
              csum_acc <= csum_acc ^ iRxData;
              if (byte_idx == 2'd3) begin
                oIwWriteEnable <= 1'b1;
                oIwAddress     <= wr_addr;
                oIwWriteData   <= {iRxData, word_sr[31:8]};
                wr_addr        <= wr_addr + 32'd4;
                word_cnt       <= word_cnt + 16'd1;
              end
            end
          end
          S_CSUM: begin
            if (iRxValid) begin
              if (iRxData == csum_acc) begin
                oBootDone  <= 1'b1;
                oInitialPC <= start_addr;
                oCPUReset  <= 1'b0;
              end else begin
                oError   <= 1'b1;
                oErrCode <= ERR_CSUM;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
